// File: rtl/ni_inject.sv
`default_nettype none
// ============================================================================
//  Module   : ni_inject
//  Purpose  : Network-interface transmitter. Buffers flits from the local PE,
//             allocates a free virtual channel per packet (round-robin) and
//             injects flits one at a time into the router's local input port
//             under the per-VC ack/ready/lock feedback.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock
//    reset        in   asynchronous active-low reset
//    pe_data      in   flit from PE; [DW-1:DW-2] = type (01 head, 00 body,
//                      10 tail, 11 single)
//    pe_valid     in   PE flit valid
//    pe_ready     out  FIFO can accept a flit
//    odata        out  flit to router
//    ovalid       out  flit valid to router
//    ovch         out  VC index of the flit
//    iack         in   per-VC flit accepted
//    irdy         in   per-VC buffer space available
//    ilck         in   per-VC owned by another packet
//    busy         out  FSM not idle or FIFO not empty
//    err_proto    out  sticky: body/tail without open packet, or head inside
//                      an open packet
//    err_timeout  out  sticky: no ack within TIMEOUT cycles in SEND
//    pkt_cnt      out  completed packets (wraps)
// ============================================================================
module ni_inject #(
    parameter int ROUTERID   = 0,
    parameter int DATA_WIDTH = 32,
    parameter int VCH        = 4,
    parameter int VCH_NUM    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pe_data,
    input  logic                  pe_valid,
    output logic                  pe_ready,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  ovalid,
    output logic [VCH_NUM-1:0]    ovch,
    input  logic [VCH-1:0]        iack,
    input  logic [VCH-1:0]        irdy,
    input  logic [VCH-1:0]        ilck,
    output logic                  busy,
    output logic                  err_proto,
    output logic                  err_timeout,
    output logic [15:0]           pkt_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   c_depth   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   c_one     = (AW+1)'(1);
    localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT);

    // The router id is informational only; this empty block merely keeps
    // the parameter referenced.
    if (ROUTERID < 0) begin : g_routerid_info
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_SEND  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // PE flit FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [AW-1:0]         w_rd_ptr_p1;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_head_next;
    logic                  w_head_start;
    logic                  w_head_end;

    // pe_ready depends only on registered occupancy, never on this cycle's pop.
    assign w_full       = (r_count == c_depth);
    assign w_empty      = (r_count == '0);
    assign w_push       = pe_valid & ~w_full;
    assign w_rd_ptr_p1  = r_rd_ptr + 1'b1;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_next  = r_mem[w_rd_ptr_p1];
    assign w_head_start = w_head[DATA_WIDTH-2];   // head (01) or single (11)
    assign w_head_end   = w_head[DATA_WIDTH-1];   // tail (10) or single (11)

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pe_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_p1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin VC pick: first eligible VC at or above rr_ptr, wrapping
    // ------------------------------------------------------------------
    logic [VCH_NUM-1:0] r_rr_ptr;
    logic [VCH-1:0]     w_elig;
    logic               w_found;
    logic [VCH_NUM-1:0] w_pick;

    assign w_elig = irdy & ~ilck;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < VCH; i++) begin
            if (!w_found && w_elig[VCH_NUM'((int'(r_rr_ptr) + i) % VCH)]) begin
                w_found = 1'b1;
                w_pick  = VCH_NUM'((int'(r_rr_ptr) + i) % VCH);
            end
        end
    end

    // ------------------------------------------------------------------
    // Injection FSM
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ovalid;
    logic                  w_ovalid_nxt;
    logic [DATA_WIDTH-1:0] r_odata;
    logic [DATA_WIDTH-1:0] w_odata_nxt;
    logic [VCH_NUM-1:0]    r_ovch;
    logic [VCH_NUM-1:0]    w_ovch_nxt;
    logic [VCH_NUM-1:0]    w_rr_nxt;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer_nxt;
    logic [TW-1:0]         w_timer_inc;
    logic                  r_err_proto;
    logic                  w_err_proto_nxt;
    logic                  r_err_timeout;
    logic                  w_err_timeout_nxt;
    logic [15:0]           r_pkt_cnt;
    logic [15:0]           w_pkt_nxt;

    // Timer saturates at TIMEOUT so the sticky flag never re-arms.
    assign w_timer_inc = (r_timer == c_timeout) ? r_timer : r_timer + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_ovalid      <= 1'b0;
            r_odata       <= '0;
            r_ovch        <= '0;
            r_rr_ptr      <= '0;
            r_timer       <= '0;
            r_err_proto   <= 1'b0;
            r_err_timeout <= 1'b0;
            r_pkt_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ovalid      <= w_ovalid_nxt;
            r_odata       <= w_odata_nxt;
            r_ovch        <= w_ovch_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_timer       <= w_timer_nxt;
            r_err_proto   <= w_err_proto_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_pkt_cnt     <= w_pkt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pop             = 1'b0;
        w_ovalid_nxt      = r_ovalid;
        w_odata_nxt       = r_odata;
        w_ovch_nxt        = r_ovch;
        w_rr_nxt          = r_rr_ptr;
        w_timer_nxt       = r_timer;
        w_err_proto_nxt   = r_err_proto;
        w_err_timeout_nxt = r_err_timeout;
        w_pkt_nxt         = r_pkt_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_start) begin
                        w_state_nxt = S_ALLOC;
                    end else begin
                        // Orphan body/tail: discard it.
                        w_pop           = 1'b1;
                        w_err_proto_nxt = 1'b1;
                    end
                end
            end

            S_ALLOC: begin
                if (w_found) begin
                    w_ovch_nxt   = w_pick;
                    w_rr_nxt     = VCH_NUM'((int'(w_pick) + 1) % VCH);
                    w_odata_nxt  = w_head;
                    w_ovalid_nxt = 1'b1;
                    w_state_nxt  = S_SEND;
                end else begin
                    w_ovalid_nxt = 1'b0;
                end
            end

            S_SEND: begin
                // The flit in odata is always the FIFO head while in SEND.
                if (iack[r_ovch]) begin
                    w_pop       = 1'b1;
                    w_timer_nxt = '0;
                    if (w_head_end) begin
                        w_pkt_nxt    = r_pkt_cnt + 16'd1;
                        w_ovalid_nxt = 1'b0;
                        w_state_nxt  = S_IDLE;
                    end else if ((r_count > c_one) && irdy[r_ovch]) begin
                        w_odata_nxt = w_head_next;
                    end else begin
                        w_ovalid_nxt = 1'b0;
                        w_state_nxt  = S_HOLD;
                    end
                end else begin
                    w_timer_nxt = w_timer_inc;
                    if (w_timer_inc == c_timeout) begin
                        w_err_timeout_nxt = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (!w_empty) begin
                    if (w_head_start) begin
                        // A new packet start inside an open packet: discard it.
                        w_pop           = 1'b1;
                        w_err_proto_nxt = 1'b1;
                    end else if (irdy[r_ovch]) begin
                        w_odata_nxt  = w_head;
                        w_ovalid_nxt = 1'b1;
                        w_state_nxt  = S_SEND;
                    end
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_ovalid_nxt = 1'b0;
            end
        endcase
    end

    assign pe_ready    = ~w_full;
    assign odata       = r_odata;
    assign ovalid      = r_ovalid;
    assign ovch        = r_ovch;
    assign busy        = (r_state != S_IDLE) | ~w_empty;
    assign err_proto   = r_err_proto;
    assign err_timeout = r_err_timeout;
    assign pkt_cnt     = r_pkt_cnt;

endmodule
`default_nettype wire
